// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Shares the regfile write port between the writeback stage and a
//            buffered mul/div result FIFO, with aging-based port stealing.
// Options  : WB_ARB_PERF_EN enables the saturating perf counters.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_WAIT   = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pipe_valid,
  input  logic             pipe_we,
  input  logic [4:0]       pipe_rd,
  input  logic [31:0]      pipe_data,
  output logic             pipe_stall,
  input  logic             md_valid,
  input  logic [4:0]       md_rd,
  input  logic [31:0]      md_data,
  output logic             md_ready,
  output logic [31:0]      md_pend_mask,
  output logic             rf_we,
  output logic [4:0]       rf_rd,
  output logic [31:0]      rf_data,
  output logic [CNT_W-1:0] perf_conflicts,
  output logic [CNT_W-1:0] perf_steals
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [PTR_W:0]    C_DEPTH     = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [WAIT_W-1:0] C_WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  typedef enum logic [0:0] {
    ST_PRI   = 1'b0,
    ST_STEAL = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WAIT_W-1:0] r_wait;
  logic [WAIT_W-1:0] w_wait_nxt;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W:0]    r_count;
  logic [FIFO_DEPTH-1:0] r_ent_vld;
  logic [4:0]        r_ent_rd   [FIFO_DEPTH];
  logic [31:0]       r_ent_data [FIFO_DEPTH];

  logic        w_pipe_wr;
  logic        w_fifo_nonempty;
  logic        w_head_live;
  logic [4:0]  w_head_rd;
  logic [31:0] w_head_data;
  logic        w_pop;
  logic        w_push;
  logic        w_pipe_sel;
  logic        w_head_out;
  logic        w_stall_raw;
  logic [31:0] w_mask;

  assign w_pipe_wr       = pipe_valid & pipe_we & (pipe_rd != 5'd0);
  assign w_fifo_nonempty = (r_count != '0);
  // Valid bits are cleared on pop, so a set bit always marks a live entry.
  assign w_head_live     = r_ent_vld[r_rd_ptr];
  assign w_head_rd       = r_ent_rd[r_rd_ptr];
  assign w_head_data     = r_ent_data[r_rd_ptr];
  assign md_ready        = (r_count < C_DEPTH);
  assign w_push          = md_valid & md_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait;
    w_pop       = 1'b0;
    w_pipe_sel  = 1'b0;
    w_head_out  = 1'b0;
    w_stall_raw = 1'b0;
    case (r_state)
      ST_PRI: begin
        if (w_pipe_wr) begin
          w_pipe_sel = 1'b1;
          if (w_head_live) begin
            w_wait_nxt = r_wait + WAIT_W'(1);
            // A head killed by this very write must not trigger a steal.
            if ((r_wait == C_WAIT_LAST) && (pipe_rd != w_head_rd))
              w_state_nxt = ST_STEAL;
          end
        end else if (w_fifo_nonempty) begin
          w_pop      = 1'b1;
          w_head_out = w_head_live;
          w_wait_nxt = '0;
        end
      end
      ST_STEAL: begin
        w_stall_raw = 1'b1;
        w_pop       = w_fifo_nonempty;
        w_head_out  = w_head_live;
        w_wait_nxt  = '0;
        w_state_nxt = ST_PRI;
      end
      default: begin
        w_state_nxt = ST_PRI;
        w_wait_nxt  = '0;
      end
    endcase
  end

  always_comb begin
    rf_we   = ~rst & (w_pipe_sel | w_head_out);
    rf_rd   = 5'd0;
    rf_data = 32'd0;
    if (rf_we) begin
      rf_rd   = w_pipe_sel ? pipe_rd   : w_head_rd;
      rf_data = w_pipe_sel ? pipe_data : w_head_data;
    end
  end

  assign pipe_stall = ~rst & w_stall_raw;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (r_ent_vld[i]) w_mask[r_ent_rd[i]] = 1'b1;
    end
  end

  assign md_pend_mask = w_mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_PRI;
      r_wait    <= '0;
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_ent_vld <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_ent_rd[i]   <= 5'd0;
        r_ent_data[i] <= 32'd0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= w_wait_nxt;
      // A pipe write supersedes every older MD result for the same register.
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (w_pipe_sel && (r_ent_rd[i] == pipe_rd)) r_ent_vld[i] <= 1'b0;
      end
      if (w_pop) begin
        r_ent_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr            <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push) begin
        r_ent_rd[r_wr_ptr]   <= md_rd;
        r_ent_data[r_wr_ptr] <= md_data;
        r_ent_vld[r_wr_ptr]  <= (md_rd != 5'd0) & ~(w_pipe_sel & (md_rd == pipe_rd));
        r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef WB_ARB_PERF_EN
  logic [CNT_W-1:0] r_perf_conf;
  logic [CNT_W-1:0] r_perf_steal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_conf  <= '0;
      r_perf_steal <= '0;
    end else begin
      if (w_pipe_wr && w_fifo_nonempty && !(&r_perf_conf))
        r_perf_conf <= r_perf_conf + CNT_W'(1);
      if ((r_state == ST_STEAL) && !(&r_perf_steal))
        r_perf_steal <= r_perf_steal + CNT_W'(1);
    end
  end

  assign perf_conflicts = r_perf_conf;
  assign perf_steals    = r_perf_steal;
`else
  assign perf_conflicts = '0;
  assign perf_steals    = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_arbiter
// Purpose  : Directed self-checking bench for regfile_wb_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        pipe_valid;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        pipe_stall;
  logic        md_valid;
  logic [4:0]  md_rd;
  logic [31:0] md_data;
  logic        md_ready;
  logic [31:0] md_pend_mask;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;
  logic [31:0] perf_conflicts;
  logic [31:0] perf_steals;

  int errors = 0;
  int checks = 0;

  regfile_wb_arbiter #(.FIFO_DEPTH(2), .MAX_WAIT(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .pipe_valid(pipe_valid), .pipe_we(pipe_we), .pipe_rd(pipe_rd),
    .pipe_data(pipe_data), .pipe_stall(pipe_stall),
    .md_valid(md_valid), .md_rd(md_rd), .md_data(md_data),
    .md_ready(md_ready), .md_pend_mask(md_pend_mask),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_data(rf_data),
    .perf_conflicts(perf_conflicts), .perf_steals(perf_steals)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs after the falling edge; outputs settle before the next rise.
  task automatic cyc(input logic pv, input logic pw, input logic [4:0] prd, input logic [31:0] pd,
                     input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    @(negedge clk);
    pipe_valid = pv; pipe_we = pw; pipe_rd = prd; pipe_data = pd;
    md_valid = mv; md_rd = mrd; md_data = md;
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic we, input logic [4:0] rd, input logic [31:0] d);
    chk({tag, ".we"}, {31'd0, rf_we}, {31'd0, we});
    chk({tag, ".rd"}, {27'd0, rf_rd}, {27'd0, rd});
    chk({tag, ".data"}, rf_data, d);
  endtask

  initial begin
    rst = 1'b1;
    pipe_valid = 0; pipe_we = 0; pipe_rd = 0; pipe_data = 0;
    md_valid = 0; md_rd = 0; md_data = 0;
    #1;
    chk_wr("reset", 1'b0, 5'd0, 32'd0);
    chk("reset.stall", {31'd0, pipe_stall}, 32'd0);
    chk("reset.ready", {31'd0, md_ready}, 32'd1);
    chk("reset.mask", md_pend_mask, 32'd0);
    chk("reset.pconf", perf_conflicts, 32'd0);
    chk("reset.psteal", perf_steals, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Pipe pass-through and filtering of non-writes
    cyc(1, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
    chk_wr("t1.pass", 1'b1, 5'd5, 32'hDEADBEEF);
    chk("t1.stall", {31'd0, pipe_stall}, 32'd0);
    cyc(1, 1, 5'd0, 32'h1111, 0, 0, 0);
    chk_wr("t1.rd0", 1'b0, 5'd0, 32'd0);
    cyc(1, 0, 5'd6, 32'h2222, 0, 0, 0);
    chk_wr("t1.nowe", 1'b0, 5'd0, 32'd0);

    // MD result on idle port
    cyc(0, 0, 0, 0, 1, 5'd7, 32'h1234);
    chk("t2.ready", {31'd0, md_ready}, 32'd1);
    chk_wr("t2.enq", 1'b0, 5'd0, 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk_wr("t2.pop", 1'b1, 5'd7, 32'h1234);
    chk("t2.mask", md_pend_mask, 32'h80);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk_wr("t2.idle", 1'b0, 5'd0, 32'd0);
    chk("t2.mask0", md_pend_mask, 32'd0);

    // Starvation steal
    cyc(1, 1, 5'd10, 32'hA0, 1, 5'd3, 32'h3333);
    chk_wr("t3.c0", 1'b1, 5'd10, 32'hA0);
    for (int k = 1; k <= 4; k++) begin
      cyc(1, 1, 5'(10 + k), 32'hA0 + 32'(k), 0, 0, 0);
      chk_wr("t3.pipe", 1'b1, 5'(10 + k), 32'hA0 + 32'(k));
      chk("t3.nostall", {31'd0, pipe_stall}, 32'd0);
      chk("t3.mask", md_pend_mask, 32'h8);
    end
    cyc(1, 1, 5'd20, 32'hB5, 0, 0, 0);
    chk("t3.stall", {31'd0, pipe_stall}, 32'd1);
    chk_wr("t3.steal", 1'b1, 5'd3, 32'h3333);
    cyc(1, 1, 5'd20, 32'hB5, 0, 0, 0);
    chk("t3.unstall", {31'd0, pipe_stall}, 32'd0);
    chk_wr("t3.replay", 1'b1, 5'd20, 32'hB5);
    chk("t3.mask0", md_pend_mask, 32'd0);

    // Kill of a buffered entry, then kill of a same-cycle enqueue
    cyc(1, 1, 5'd1, 32'h11, 1, 5'd9, 32'h9999);
    cyc(1, 1, 5'd9, 32'h99AA, 0, 0, 0);
    chk("t4.mask9", md_pend_mask, 32'h200);
    chk_wr("t4.pipe9", 1'b1, 5'd9, 32'h99AA);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("t4.killed", md_pend_mask, 32'd0);
    chk_wr("t4.deadpop", 1'b0, 5'd0, 32'd0);
    cyc(1, 1, 5'd6, 32'h66, 1, 5'd6, 32'h6060);
    chk_wr("t4.same", 1'b1, 5'd6, 32'h66);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("t4.samemask", md_pend_mask, 32'd0);
    chk_wr("t4.samepop", 1'b0, 5'd0, 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk_wr("t4.empty", 1'b0, 5'd0, 32'd0);

    // FIFO full under continuous pipe writes
    cyc(1, 1, 5'd1, 32'h1, 1, 5'd4, 32'h44);
    chk("t5.rdy0", {31'd0, md_ready}, 32'd1);
    cyc(1, 1, 5'd2, 32'h2, 1, 5'd5, 32'h55);
    chk("t5.rdy1", {31'd0, md_ready}, 32'd1);
    cyc(1, 1, 5'd1, 32'h3, 1, 5'd6, 32'h66);
    chk("t5.full", {31'd0, md_ready}, 32'd0);
    chk("t5.mask", md_pend_mask, 32'h30);
    cyc(1, 1, 5'd2, 32'h4, 1, 5'd6, 32'h66);
    chk("t5.full2", {31'd0, md_ready}, 32'd0);
    cyc(1, 1, 5'd1, 32'h5, 1, 5'd6, 32'h66);
    chk_wr("t5.c4", 1'b1, 5'd1, 32'h5);
    cyc(1, 1, 5'd2, 32'h6, 1, 5'd6, 32'h66);
    chk("t5.stall", {31'd0, pipe_stall}, 32'd1);
    chk_wr("t5.steal", 1'b1, 5'd4, 32'h44);
    chk("t5.nobypass", {31'd0, md_ready}, 32'd0);
    cyc(1, 1, 5'd2, 32'h6, 1, 5'd6, 32'h66);
    chk_wr("t5.replay", 1'b1, 5'd2, 32'h6);
    chk("t5.rdy", {31'd0, md_ready}, 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk_wr("t5.pop5", 1'b1, 5'd5, 32'h55);
    chk("t5.mask56", md_pend_mask, 32'h60);
    chk("t5.full3", {31'd0, md_ready}, 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk_wr("t5.pop6", 1'b1, 5'd6, 32'h66);
    chk("t5.mask6", md_pend_mask, 32'h40);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk_wr("t5.empty", 1'b0, 5'd0, 32'd0);
    chk("t5.mask0", md_pend_mask, 32'd0);

    // Reset while stealing with a full FIFO
    cyc(1, 1, 5'd1, 32'h1, 1, 5'd8, 32'h88);
    cyc(1, 1, 5'd2, 32'h2, 1, 5'd12, 32'hCC);
    cyc(1, 1, 5'd1, 32'h3, 0, 0, 0);
    cyc(1, 1, 5'd2, 32'h4, 0, 0, 0);
    cyc(1, 1, 5'd1, 32'h5, 0, 0, 0);
    cyc(1, 1, 5'd2, 32'h6, 0, 0, 0);
    chk("t6.stall", {31'd0, pipe_stall}, 32'd1);
    chk("t6.fullmask", md_pend_mask, 32'h1100);
    rst = 1'b1;
    #1;
    chk("t6.rst.stall", {31'd0, pipe_stall}, 32'd0);
    chk_wr("t6.rst", 1'b0, 5'd0, 32'd0);
    chk("t6.rst.ready", {31'd0, md_ready}, 32'd1);
    chk("t6.rst.mask", md_pend_mask, 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    #1;
    chk_wr("t6.post0", 1'b0, 5'd0, 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk_wr("t6.post1", 1'b0, 5'd0, 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk_wr("t6.post2", 1'b0, 5'd0, 32'd0);
    chk("t6.post.stall", {31'd0, pipe_stall}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
